btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Conditions the raw board push-button (active-low btn1) before it reaches the CPU/LED core.
//  Synchronises, debounces and edge-detects the button.
//  Short presses: one-cycle press/release pulses for user input.
//  Long press: generates a stretched active-low cpu_resetn that drives the cpu core reset.
//  Also stretches cpu_resetn low after system reset (power-on reset for the core).
// PARAMETERS
//  BTN_ACTIVE_LOW   1         1: btn_raw=0 means pressed; 0: btn_raw=1 means pressed
//  DEBOUNCE_CYCLES  270000    stable cycles needed to accept a level change (10 ms @ 27 MHz); >=1
//  LONG_CYCLES      27000000  cycles the debounced press must persist to be a long press; >=1
//  RST_STRETCH      16        cycles cpu_resetn is held low; >=1
// PORTS
//  clk            in   1  system clock; single domain
//  reset          in   1  asynchronous reset, active-high
//  btn_raw        in   1  raw asynchronous button pin
//  btn_level      out  1  debounced level, 1 = pressed
//  press_pulse    out  1  one-cycle pulse on accepted press
//  release_pulse  out  1  one-cycle pulse on accepted release
//  long_pulse     out  1  one-cycle pulse when a held press reaches LONG_CYCLES
//  cpu_resetn     out  1  active-low reset to the cpu core, stretched
// BEHAVIOUR
//  Reset values:
//   - Synchroniser flops load the released level (1 if BTN_ACTIVE_LOW).
//   - State = IDLE; all counters = 0; btn_level = 0; all pulses = 0; cpu_resetn = 0.
//  Input path: 2-flop synchroniser, then polarity normalisation -> btn_s (1 = pressed).
//  Counter widths: $clog2 of their max value; no wrap is reachable.
//  States:
//   - IDLE: btn_s=1 -> PRESS_WAIT, db_cnt=0.
//   - PRESS_WAIT:
//     - btn_s=0 -> IDLE (bounce rejected, no pulse).
//     - db_cnt==DEBOUNCE_CYCLES-1 -> HELD; press_pulse, btn_level<=1, hold_cnt=0.
//     - Otherwise db_cnt++.
//   - HELD:
//     - btn_s=0 -> REL_WAIT, db_cnt=0.
//     - hold_cnt==LONG_CYCLES-1 -> LONG_HELD; long_pulse.
//     - Otherwise hold_cnt++.
//   - LONG_HELD: btn_s=0 -> REL_WAIT, db_cnt=0; long_pulse never repeats within one press.
//   - REL_WAIT:
//     - btn_s=1 -> back to HELD or LONG_HELD (remembered flag); hold_cnt frozen, not cleared.
//     - db_cnt==DEBOUNCE_CYCLES-1 -> IDLE; release_pulse, btn_level<=0.
//     - Otherwise db_cnt++.
//  Latency:
//   - With a steady input, press_pulse is high for exactly 1 cycle.
//   - It starts DEBOUNCE_CYCLES+2 clocks after the edge that first samples the pressed pin.
//   - release_pulse has the same latency from the release.
//  Timing:
//   - Pulses are registered; at most one of press/release/long is high in any cycle.
//   - btn_level changes in the same cycle its pulse is high.
//  cpu_resetn:
//   - Down-counter rst_cnt, loaded with RST_STRETCH-1 by reset.
//   - cpu_resetn stays 0 while rst_cnt!=0 and goes 1 the cycle after rst_cnt reaches 0.
//   - So it is low for RST_STRETCH cycles after reset deasserts.
//   - A long press reloads rst_cnt in the long_pulse cycle and drives cpu_resetn 0 from the next cycle.
//   - A long press during an active stretch restarts the stretch.
//   - Short presses never touch cpu_resetn.
//  Reset mid-operation:
//   - Asserting reset in any state returns everything to reset values immediately.
//   - No release_pulse is emitted for a press aborted by reset.
//   - A button still held after reset is re-debounced from IDLE.
// TESTING (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, RST_STRETCH=3, BTN_ACTIVE_LOW=1)
//  1 POR: pulse reset 2 cycles, btn_raw=1 -> cpu_resetn=0 for 3 clocks after release, then 1;
//    all pulses 0.
//  2 Clean press: btn_raw 1->0 held 10 cycles ->
//    press_pulse high exactly 1 cycle at sample-edge+6; btn_level=1; cpu_resetn stays 1.
//  3 Bounce: btn_raw low for 3 cycles then high -> no pulse, btn_level=0;
//    glitch high 2 cycles during HELD -> no release_pulse, hold_cnt continues after glitch.
//  4 Long press: hold low 40 cycles ->
//    press_pulse, then long_pulse 20 cycles later;
//    cpu_resetn low for 3 cycles starting the cycle after long_pulse;
//    on release, one release_pulse 6 cycles after the release sample edge.
//  5 Reset mid-press: assert reset while in HELD ->
//    btn_level=0 at once, no release_pulse;
//    button still held -> new press_pulse 6 cycles after reset deassert.
//  6 Polarity: BTN_ACTIVE_LOW=0, btn_raw 0->1 -> press_pulse at +6 cycles.

Source files
------------

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Conditions the raw board push-button before it reaches the CPU/LED core.
// The pin is synchronised (2 flops) and its polarity normalised. A small FSM
// then debounces it and emits registered one-cycle pulses for accepted presses,
// accepted releases and long presses. A long press, and every system reset,
// stretch the active-low cpu_resetn output for RST_STRETCH cycles.
//
// Parameters
//   BTN_ACTIVE_LOW   1: btn_raw=0 means pressed; 0: btn_raw=1 means pressed
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>=1)
//   LONG_CYCLES      cycles a debounced press must persist to be long (>=1)
//   RST_STRETCH      cycles cpu_resetn is held low (>=1)
//
// Ports
//   clk            in   system clock, single domain
//   reset          in   asynchronous reset, active-high
//   btn_raw        in   raw asynchronous button pin
//   btn_level      out  debounced level, 1 = pressed
//   press_pulse    out  one-cycle pulse on an accepted press
//   release_pulse  out  one-cycle pulse on an accepted release
//   long_pulse     out  one-cycle pulse when a held press reaches LONG_CYCLES
//   cpu_resetn     out  stretched active-low reset to the cpu core
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int RST_STRETCH     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic cpu_resetn
);

    // Counter widths: each counter only ever holds 0 .. MAX-1.
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_CYCLES > 1)     ? $clog2(LONG_CYCLES)     : 1;
    localparam int RST_W  = (RST_STRETCH > 1)     ? $clog2(RST_STRETCH)     : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RST_STRETCH - 1);
    localparam logic [RST_W-1:0]  RST_ONE   = RST_W'(1);

    // Pin level that means "not pressed"; synchroniser flops reset to it so a
    // reset never looks like a press edge.
    localparam logic RELEASED = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_WAIT = 3'd1,
        HELD       = 3'd2,
        LONG_HELD  = 3'd3,
        REL_WAIT   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and polarity normalisation
    // ------------------------------------------------------------------
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic btn_s;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        btn_s   = (BTN_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ------------------------------------------------------------------
    // Debounce / long-press FSM
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                long_flag_q, long_flag_d;   // current press already went long
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                rel_q, rel_d;
    logic                long_q, long_d;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        level_d     = level_q;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end

            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;               // bounce rejected
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_flag_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            HELD: begin
                if (!btn_s) begin
                    state_d  = REL_WAIT;
                    db_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = LONG_HELD;
                    long_d      = 1'b1;
                    long_flag_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end

            LONG_HELD: begin
                // hold_cnt parked; long_pulse fires once per press
                if (!btn_s) begin
                    state_d  = REL_WAIT;
                    db_cnt_d = '0;
                end
            end

            REL_WAIT: begin
                if (btn_s) begin
                    // Release was a glitch: resume where we were, hold_cnt
                    // kept so a glitch does not restart the long-press timer.
                    state_d = long_flag_q ? LONG_HELD : HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    level_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
        end
    end

    // ------------------------------------------------------------------
    // cpu_resetn stretcher
    // rst_cnt counts down to 0; cpu_resetn rises the cycle after it gets
    // there. A registered long_pulse reloads it, so the core reset starts
    // the cycle after long_pulse and lasts RST_STRETCH cycles.
    // ------------------------------------------------------------------
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             cpu_resetn_q, cpu_resetn_d;

    always_comb begin
        rst_cnt_d    = rst_cnt_q;
        cpu_resetn_d = 1'b1;
        if (long_q) begin
            rst_cnt_d    = RST_LOAD;
            cpu_resetn_d = 1'b0;
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d    = rst_cnt_q - RST_ONE;
            cpu_resetn_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt_q    <= RST_LOAD;
            cpu_resetn_q <= 1'b0;
        end else begin
            rst_cnt_q    <= rst_cnt_d;
            cpu_resetn_q <= cpu_resetn_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;
    assign cpu_resetn    = cpu_resetn_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Two instances: dut_a is active-low, dut_b is active-high and is fed the
// inverted pin, so both must behave identically. A behavioural model tracks
// the debounced button as "runs of consecutive samples differing from the
// accepted level" plus a count of steady held samples and the cycle at which
// the current cpu reset stretch began. Directed segments check the latencies
// derived for DEBOUNCE=4, LONG=20, STRETCH=3; random segments follow.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int RST  = 3;

    logic clk = 1'b0;
    logic reset;
    logic raw_a, raw_b;
    logic lvl_a, pp_a, rp_a, lp_a, rn_a;
    logic lvl_b, pp_b, rp_b, lp_b, rn_b;

    always #5 clk = ~clk;

    btn_conditioner #(.BTN_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG),
                      .RST_STRETCH(RST)) dut_a (
        .clk(clk), .reset(reset), .btn_raw(raw_a), .btn_level(lvl_a),
        .press_pulse(pp_a), .release_pulse(rp_a), .long_pulse(lp_a), .cpu_resetn(rn_a));

    btn_conditioner #(.BTN_ACTIVE_LOW(0), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG),
                      .RST_STRETCH(RST)) dut_b (
        .clk(clk), .reset(reset), .btn_raw(raw_b), .btn_level(lvl_b),
        .press_pulse(pp_b), .release_pulse(rp_b), .long_pulse(lp_b), .cpu_resetn(rn_b));

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    bit hist[$];          // pressed-ness seen by the FSM two edges later
    bit cur_pressed;
    bit m_level, m_press, m_rel, m_long, m_fired, m_cpu;
    int m_run, m_steps, m_k, m_trig;

    // ---------------- segment bookkeeping ----------------
    int tidx, p_at, pb_at, r_at, l_at, p_cnt, r_cnt, l_cnt;
    int c_low_cnt, c_low_first, c_hi_first;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist    = '{1'b0, 1'b0};
        m_level = 0; m_press = 0; m_rel = 0; m_long = 0; m_fired = 0; m_cpu = 0;
        m_run   = 0; m_steps = 0; m_k = 0; m_trig = 0;
    endtask

    task automatic model_step();
        bit s;
        int run_before;
        s = hist.pop_front();
        hist.push_back(cur_pressed);
        m_k++;
        // a long pulse seen before this edge starts a fresh stretch here
        if (m_long) m_trig = m_k;
        m_cpu   = (m_k >= m_trig + RST);
        m_press = 0; m_rel = 0; m_long = 0;
        run_before = m_run;
        m_run = (s != m_level) ? m_run + 1 : 0;
        if (m_run == DB + 1) begin
            m_level = s;
            m_run   = 0;
            if (s) begin
                m_press = 1; m_steps = 0; m_fired = 0;
            end else begin
                m_rel = 1;
            end
        end else if (m_level && s && run_before == 0 && !m_fired) begin
            m_steps++;
            if (m_steps == LONG) begin
                m_long  = 1;
                m_fired = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("level_a", lvl_a, m_level);  chk("level_b", lvl_b, m_level);
        chk("press_a", pp_a, m_press);   chk("press_b", pp_b, m_press);
        chk("rel_a",   rp_a, m_rel);     chk("rel_b",   rp_b, m_rel);
        chk("long_a",  lp_a, m_long);    chk("long_b",  lp_b, m_long);
        chk("cpurn_a", rn_a, m_cpu);     chk("cpurn_b", rn_b, m_cpu);
    endtask

    task automatic mark();
        tidx = 0; p_at = -1; pb_at = -1; r_at = -1; l_at = -1;
        p_cnt = 0; r_cnt = 0; l_cnt = 0;
        c_low_cnt = 0; c_low_first = -1; c_hi_first = -1;
    endtask

    task automatic tick(input bit pressed);
        cur_pressed = pressed;
        raw_a = ~pressed;
        raw_b = pressed;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (pp_a) begin p_cnt++; if (p_at < 0) p_at = tidx; end
        if (pp_b && pb_at < 0) pb_at = tidx;
        if (rp_a) begin r_cnt++; if (r_at < 0) r_at = tidx; end
        if (lp_a) begin l_cnt++; if (l_at < 0) l_at = tidx; end
        if (!rn_a) begin
            c_low_cnt++;
            if (c_low_first < 0) c_low_first = tidx;
        end else if (c_hi_first < 0) begin
            c_hi_first = tidx;
        end
        tidx++;
    endtask

    task automatic seg(input bit pressed, input int n);
        for (int i = 0; i < n; i++) tick(pressed);
    endtask

    // reset asserted asynchronously, held over two clock edges
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_cpurn", rn_a, 1'b0);
        chk("rst_level", lvl_a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        cur_pressed = 0;
        raw_a = 1'b1;
        raw_b = 1'b0;
        do_reset();

        // 1: power-on stretch. Low before edge 1 plus after edges 1,2; high from edge 3.
        mark();
        seg(0, 6);
        chk_int("por_first_high", c_hi_first, RST - 1);
        chk_int("por_low_ticks", c_low_cnt, RST - 1);
        chk_int("por_pulses", p_cnt + r_cnt + l_cnt, 0);

        // 2: clean press, pulse DB+2 edges after the sampling edge
        mark();
        seg(1, 10);
        chk_int("press_lat_a", p_at, DB + 2);
        chk_int("press_lat_b", pb_at, DB + 2);
        chk_int("press_count", p_cnt, 1);
        chk("press_level", lvl_a, 1'b1);
        chk_int("short_cpu_low", c_low_cnt, 0);
        mark();
        seg(0, 10);
        chk_int("rel_lat", r_at, DB + 2);
        chk_int("rel_count", r_cnt, 1);

        // 3a: bounce shorter than the debounce window
        mark();
        seg(1, 3);
        seg(0, 10);
        chk_int("bounce_press", p_cnt, 0);
        chk("bounce_level", lvl_a, 1'b0);

        // 3b: 2-cycle release glitch while HELD. Counting from the glitch
        // start: hold steps 1..3 happened before it, 3 edges are lost to
        // the glitch, so the 20th step lands 21 edges after the glitch start.
        mark();
        seg(1, 8);
        mark();
        seg(0, 2);
        seg(1, 30);
        chk_int("glitch_rel", r_cnt, 0);
        chk("glitch_level", lvl_a, 1'b1);
        chk_int("glitch_long_at", l_at, 21);
        chk_int("glitch_long_cnt", l_cnt, 1);
        seg(0, 10);

        // 4: long press
        mark();
        seg(1, 40);
        chk_int("long_press_at", p_at, DB + 2);
        chk_int("long_at", l_at, DB + 2 + LONG);
        chk_int("long_cnt", l_cnt, 1);
        chk_int("long_cpu_first", c_low_first, DB + 2 + LONG + 1);
        chk_int("long_cpu_cnt", c_low_cnt, RST);
        mark();
        seg(0, 10);
        chk_int("long_rel_at", r_at, DB + 2);
        chk_int("long_rel_cnt", r_cnt, 1);
        chk("long_cpu_back", rn_a, 1'b1);

        // 5: reset while HELD, button still held afterwards
        mark();
        seg(1, 8);
        #2;
        do_reset();
        mark();
        seg(1, 10);
        chk_int("rstmid_press_at", p_at, DB + 2);
        chk_int("rstmid_press_b", pb_at, DB + 2);
        chk_int("rstmid_rel", r_cnt, 0);
        seg(0, 10);

        // random segments, with the odd asynchronous reset
        for (int n = 0; n < 250; n++) begin
            int len;
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 35) : $urandom_range(1, 7);
            seg(1'($urandom_range(0, 1)), len);
            if ($urandom_range(0, 40) == 0) begin
                #2;
                do_reset();
            end
        end
        seg(0, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
